mem_loader: RTL and testbench

- Bus initiator on the dmem valid/ready memory interface; the initiating counterpart to the UART and RAM responders.
- Consumes a byte stream, normally UART RX bytes behind a small adapter, carrying an 8-byte header followed by a payload.
- Packs the payload little-endian into 32-bit words and writes them to RAM. This lets the test SoC be loaded without rebuilding the BRAM image.
- The SoC top muxes it onto the RAM dmem port while `busy` is high, and uses `busy` to hold the CPU in reset.

---
 rtl/mem_loader_pkg.sv | 33 +++
 rtl/mem_loader_packer.sv | 45 ++++
 rtl/mem_loader.sv | 148 ++++++++++++++
 tb/tb_mem_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the byte-stream RAM loader.
// The state set is also used by the packer's mask helper users.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CHECK,
        COLLECT,
        WRITE,
        GAP,
        DRAIN,
        DONE
    } state_t;

    localparam int         HDR_BYTES  = 8;
    localparam logic [3:0] WMASK_FULL = 4'b1111;

    // One enable bit per held byte, filled from lane 0 upward.
    function automatic logic [3:0] fill_mask(input logic [2:0] count);
        logic [3:0] mask;
        mask = 4'b0000;
        case (count)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            3'd3:    mask = 4'b0111;
            3'd4:    mask = WMASK_FULL;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_loader_packer.sv
// Four-byte little-endian lane register with fill count and byte-enable mask.
// Used for both header field assembly and payload word packing.
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [2:0]  count,
    output logic [3:0]  wmask,
    output logic        full
);

    logic [31:0] word_q;
    logic [2:0]  count_q;

    // Clearing zeroes every lane, so lanes not yet filled read back as 0.
    // A simultaneous clear and shift starts a fresh word with this byte in lane 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            if (shift) begin
                word_q  <= {24'd0, data};
                count_q <= 3'd1;
            end else begin
                word_q  <= '0;
                count_q <= '0;
            end
        end else if (shift) begin
            word_q[{count_q[1:0], 3'b000} +: 8] <= data;
            count_q <= count_q + 3'd1;
        end
    end

    assign word  = word_q;
    assign count = count_q;
    assign wmask = fill_mask(count_q);
    assign full  = count_q[2];

endmodule

// File: rtl/mem_loader.sv
// Byte-stream RAM loader: 8-byte header (base, length), then payload packed
// little-endian into 32-bit words and written over the dmem valid/ready port.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000ffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic [31:0] remaining_q;
    logic [2:0]  hdr_cnt_q;
    logic        err_q;

    logic        pk_clear, pk_shift, pk_full;
    logic [31:0] pk_word;
    logic [2:0]  pk_count;
    logic [3:0]  pk_wmask;

    logic        accept;
    logic [32:0] hdr_end;
    logic        hdr_bad;

    byte_packer u_packer (
        .clk   (clk),
        .reset (reset),
        .clear (pk_clear),
        .shift (pk_shift),
        .data  (in_data),
        .word  (pk_word),
        .count (pk_count),
        .wmask (pk_wmask),
        .full  (pk_full)
    );

    assign accept = in_valid && in_ready;

    // In CHECK, addr_q holds the base and the packer holds the length.
    // The 33-bit sum makes an end address that wraps past 2^32 an error.
    assign hdr_end = {1'b0, addr_q} + {1'b0, pk_word} - 33'd1;
    assign hdr_bad = (addr_q[1:0] != 2'b00) || (hdr_end > {1'b0, ADDR_LIMIT});

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pk_clear   = 1'b0;
        pk_shift   = 1'b0;
        case (state)
            IDLE: begin
                pk_clear = 1'b1;
                pk_shift = accept;
                if (accept) state_next = HDR;
            end
            HDR: begin
                // Base field complete: move it out and reuse the packer for length.
                pk_clear = pk_full;
                pk_shift = accept;
                if (accept && hdr_cnt_q == 3'(HDR_BYTES - 1)) state_next = CHECK;
            end
            CHECK: begin
                pk_clear = 1'b1;
                if (pk_word == 32'd0) state_next = DONE;
                else if (hdr_bad)     state_next = DRAIN;
                else                  state_next = COLLECT;
            end
            COLLECT: begin
                pk_shift = accept;
                if (accept && (pk_count == 3'd3 || remaining_q == 32'd1)) state_next = WRITE;
            end
            WRITE: begin
                if (mem_ready) state_next = GAP;
            end
            GAP: begin
                pk_clear   = 1'b1;
                state_next = (remaining_q != 32'd0) ? COLLECT : DONE;
            end
            DRAIN: begin
                if (accept && remaining_q == 32'd1) state_next = DONE;
            end
            DONE: begin
                pk_clear   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            hdr_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        hdr_cnt_q <= 3'd1;
                        err_q     <= 1'b0;
                    end
                end
                HDR: begin
                    if (pk_full) addr_q <= pk_word;
                    if (accept)  hdr_cnt_q <= hdr_cnt_q + 3'd1;
                end
                CHECK: begin
                    remaining_q <= pk_word;
                    if (pk_word != 32'd0 && hdr_bad) err_q <= 1'b1;
                end
                COLLECT, DRAIN: begin
                    if (accept) remaining_q <= remaining_q - 32'd1;
                end
                WRITE: begin
                    if (mem_ready) addr_q <= addr_q + 32'd4;
                end
                default: ;
            endcase
        end
    end

    // NOTE: outputs are also gated by reset so a request drops in the reset cycle itself.
    assign in_ready  = !reset && (state inside {IDLE, HDR, COLLECT, DRAIN});
    assign mem_valid = !reset && (state == WRITE);
    assign mem_addr  = mem_valid ? addr_q   : 32'd0;
    assign mem_wmask = mem_valid ? pk_wmask : 4'd0;
    assign mem_wdata = mem_valid ? pk_word  : 32'd0;
    assign busy      = !reset && !(state inside {IDLE, DONE});
    assign done      = !reset && (state == DONE);
    assign err       = !reset && err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: header/payload loads, errors, stalls,
// slow RAM responder and reset during a write.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    int  tests  = 0;
    int  failed = 0;
    int  delay  = 1;
    int  wcnt   = 0;
    bit  stall_en = 1'b0;

    // Monitor-owned bookkeeping; the stimulus only reads it.
    wr_t wlog[$];
    int  valid_cycles = 0;
    int  gap_viol     = 0;
    int  stable_viol  = 0;
    int  hold         = 0;
    int  last_hold    = 0;
    bit  prev_pending = 1'b0;
    bit  prev_hs      = 1'b0;
    wr_t prev_req;

    mem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // RAM responder: ready is a registered response raised after `delay` cycles of valid.
    always @(posedge clk) begin
        if (reset || !mem_valid || mem_ready) begin
            mem_ready <= 1'b0;
            wcnt      <= 0;
        end else if (wcnt + 1 >= delay) begin
            mem_ready <= 1'b1;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_pending = 1'b0;
            prev_hs      = 1'b0;
            hold         = 0;
        end else begin
            if (mem_valid) valid_cycles++;
            if (mem_valid && prev_hs) gap_viol++;
            if (mem_valid && prev_pending && {mem_addr, mem_wdata, mem_wmask} != prev_req) stable_viol++;
            if (mem_valid && !mem_ready) hold++;
            if (mem_valid && mem_ready) begin
                wlog.push_back({mem_addr, mem_wdata, mem_wmask});
                last_hold = hold;
                hold      = 0;
            end
            prev_pending = mem_valid && !mem_ready;
            prev_hs      = mem_valid && mem_ready;
            prev_req     = {mem_addr, mem_wdata, mem_wmask};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (stall_en) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v);
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
    endtask

    task automatic send_header(input logic [31:0] base, input logic [31:0] len);
        send_byte(base[7:0]);
        check("hdr_start_busy", {31'd0, busy}, 32'd1);
        check("hdr_start_err", {31'd0, err}, 32'd0);
        for (int i = 1; i < 4; i++) send_byte(base[8*i +: 8]);
        send_word(len);
    endtask

    task automatic wait_done(input int bound, input logic exp_err);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_err", {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        check("done_pulse", {30'd0, done, busy}, 32'd0);
        check("err_sticky", {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic check_write(input int idx, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask);
        wr_t w;
        if (idx < wlog.size()) begin
            w = wlog[idx];
            check("wr_addr", w.addr, addr);
            check("wr_data", w.data, data);
            check("wr_mask", {28'd0, w.mask}, {28'd0, mask});
        end else begin
            check("wr_missing", 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_idx;
        int vbase;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {in_ready, mem_valid, busy, done, err, mem_wmask},
              32'd0);
        check("reset_addr_data", mem_addr | mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", {30'd0, in_ready, busy}, 32'd2);

        // Aligned full load, 1-cycle responder.
        base_idx = wlog.size();
        send_header(32'h100, 32'd8);
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
        check("write_latency", {31'd0, mem_valid}, 32'd1);
        for (int i = 4; i < 8; i++) send_byte(8'h11 + 8'(i));
        wait_done(50, 1'b0);
        check("t1_count", 32'(wlog.size() - base_idx), 32'd2);
        check_write(base_idx,     32'h100, 32'h14131211, 4'hf);
        check_write(base_idx + 1, 32'h104, 32'h18171615, 4'hf);
        check("t1_gap", 32'(gap_viol), 32'd0);

        // Partial tail word.
        base_idx = wlog.size();
        send_header(32'h200, 32'd6);
        for (int i = 0; i < 6; i++) send_byte(8'hAA + 8'(17 * i));
        wait_done(50, 1'b0);
        check("t2_count", 32'(wlog.size() - base_idx), 32'd2);
        check_write(base_idx,     32'h200, 32'hDDCCBBAA, 4'hf);
        check_write(base_idx + 1, 32'h204, 32'h0000FFEE, 4'b0011);

        // Misaligned base: payload drained, no writes.
        vbase = valid_cycles;
        send_header(32'h102, 32'd6);
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i));
        wait_done(5, 1'b1);
        check("t3_no_valid", 32'(valid_cycles - vbase), 32'd0);

        // End address past the limit.
        vbase = valid_cycles;
        send_header(32'hFFFC, 32'd8);
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i));
        wait_done(5, 1'b1);
        check("t4_no_valid", 32'(valid_cycles - vbase), 32'd0);

        // Last word ending exactly at the limit is accepted; err clears on header start.
        base_idx = wlog.size();
        send_header(32'hFFFC, 32'd4);
        send_word(32'h04030201);
        wait_done(50, 1'b0);
        check("t5_count", 32'(wlog.size() - base_idx), 32'd1);
        check_write(base_idx, 32'hFFFC, 32'h04030201, 4'hf);

        // Zero length: done two cycles after the final header byte's edge.
        vbase = valid_cycles;
        send_header(32'h500, 32'd0);
        check("t6_check_cycle", {31'd0, done}, 32'd0);
        wait_done(1, 1'b0);
        check("t6_no_valid", 32'(valid_cycles - vbase), 32'd0);

        // Slow responder and randomly stalled input.
        delay    = 5;
        stall_en = 1'b1;
        base_idx = wlog.size();
        send_header(32'h400, 32'd7);
        for (int i = 0; i < 7; i++) send_byte(8'h01 + 8'(i));
        wait_done(100, 1'b0);
        stall_en = 1'b0;
        check("t7_count", 32'(wlog.size() - base_idx), 32'd2);
        check_write(base_idx,     32'h400, 32'h04030201, 4'hf);
        check_write(base_idx + 1, 32'h404, 32'h00070605, 4'b0111);
        check("t7_stable", 32'(stable_viol), 32'd0);
        check("t7_hold", 32'(last_hold), 32'd5);

        // Reset while a write is pending.
        delay = 20;
        send_header(32'h600, 32'd4);
        send_word(32'hCAFEF00D);
        check("t8_in_write", {31'd0, mem_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t8_after_reset", {30'd0, mem_valid, busy}, 32'd0);
        reset = 1'b0;
        delay = 1;
        @(negedge clk);
        base_idx = wlog.size();
        send_header(32'h700, 32'd4);
        send_word(32'hA4A3A2A1);
        wait_done(50, 1'b0);
        check("t8_count", 32'(wlog.size() - base_idx), 32'd1);
        check_write(base_idx, 32'h700, 32'hA4A3A2A1, 4'hf);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
